// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and loader state encoding.
// Used by the loader, the imem itself and the fetch logic.
package imem_pkg;

    localparam int unsigned IMEM_DEPTH = 2048;
    localparam logic [31:0] IMEM_BASE  = 32'h0040_0000;
    localparam int unsigned IDX_W      = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/word_packer.sv
// Assembles four accepted bytes into one big-endian 32-bit word.
// word_valid is high in the cycle the fourth byte is being accepted.
module word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  bcnt;
    logic [31:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt <= '0;
            sr   <= '0;
        end else if (clear) begin
            bcnt <= '0;
            sr   <= '0;
        end else if (accept) begin
            sr   <= {sr[23:0], byte_data};
            bcnt <= bcnt + 2'd1;
        end
    end

    assign word       = sr;
    assign word_valid = accept && (bcnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction RAM, one word per WRITE cycle,
// holding the CPU in reset while a load is in progress.
module imem_loader #(
    parameter int unsigned IMEM_DEPTH = imem_pkg::IMEM_DEPTH,
    parameter logic [31:0] IMEM_BASE  = imem_pkg::IMEM_BASE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [11:0]               word_count,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic                      byte_ready,
    output logic                      we,
    output logic [imem_pkg::IDX_W-1:0] widx,
    output logic [31:0]               waddr,
    output logic [31:0]               wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      cpu_rst_n,
    output logic [31:0]               checksum
);

    import imem_pkg::*;

    localparam logic [11:0] DEPTH_W = 12'(IMEM_DEPTH);

    state_t       state, nstate;
    logic [11:0]  cnt_q, cnt_clamped;
    logic [IDX_W-1:0] widx_q;
    logic [31:0]  csum_q;
    logic         done_q, cpu_rst_q;
    logic         load, accept, last, word_valid;

    assign load        = start && !abort && (state == IDLE || state == DONE);
    assign accept      = byte_valid && byte_ready && !abort;
    assign cnt_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
    assign last        = ({1'b0, widx_q} == (cnt_q - 12'd1));

    word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load || abort),
        .accept     (accept),
        .byte_data  (byte_data),
        .word       (wdata),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (abort) begin
            nstate = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) nstate = (cnt_clamped == '0) ? DONE : RECV;
                RECV:       if (word_valid) nstate = WRITE;
                WRITE:      nstate = last ? DONE : RECV;
                default:    nstate = IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ready = (state == RECV);
        we         = (state == WRITE) && !abort;
        busy       = (state == RECV) || (state == WRITE);
    end

    // done tracks "next state is DONE" so start/abort clearing and re-entry fall out naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            widx_q    <= '0;
            csum_q    <= '0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            cpu_rst_q <= 1'b1;
            done_q    <= (nstate == DONE);
            if (load) begin
                cnt_q  <= cnt_clamped;
                widx_q <= '0;
                csum_q <= '0;
            end else if (we) begin
                csum_q <= csum_q ^ wdata;
                if (!last) widx_q <= widx_q + 1'b1;
            end
        end
    end

    assign widx      = widx_q;
    assign waddr     = IMEM_BASE + {19'd0, widx_q, 2'b00};
    assign checksum  = csum_q;
    assign done      = done_q;
    assign cpu_rst_n = cpu_rst_q && !busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, packing/write sequencing, stalls,
// zero-length, abort, clamping and asynchronous reset during a write.
module tb_imem_loader;

    logic        clk, rst_n, start, abort, byte_valid;
    logic [11:0] word_count;
    logic [7:0]  byte_data;
    logic        byte_ready, we, busy, done, cpu_rst_n;
    logic [10:0] widx;
    logic [31:0] waddr, wdata, checksum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accepts = 0;
    logic [10:0] lw_idx[$];
    logic [31:0] lw_addr[$];
    logic [31:0] lw_data[$];

    imem_loader #(.IMEM_DEPTH(2048), .IMEM_BASE(32'h0040_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .we(we), .widx(widx), .waddr(waddr),
        .wdata(wdata), .busy(busy), .done(done), .cpu_rst_n(cpu_rst_n),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs only change 2ns after a rising edge, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (byte_valid && byte_ready) accepts++;
        if (we) begin
            lw_idx.push_back(widx);
            lw_addr.push_back(waddr);
            lw_data.push_back(wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic clear_log();
        accepts = 0;
        lw_idx.delete();
        lw_addr.delete();
        lw_data.delete();
    endtask

    task automatic do_start(input logic [11:0] n);
        word_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        byte_valid = 1'b1;
        byte_data = b;
        for (int k = 0; k < 20 && !sent; k++) begin
            if (byte_ready) sent = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (!sent) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout got=no_ready exp=ready byte=%02h", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL rst_byte_ready got=%b exp=0", byte_ready); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", we); end
        checks++; if (widx !== 11'd0) begin failures++; $display("FAIL rst_widx got=%0d exp=0", widx); end
        checks++; if (waddr !== 32'h0040_0000) begin failures++; $display("FAIL rst_waddr got=%h exp=00400000", waddr); end
        checks++; if (wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", wdata); end
        checks++; if (checksum !== 32'h0) begin failures++; $display("FAIL rst_checksum got=%h exp=0", checksum); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n got=%b exp=0", cpu_rst_n); end
        tick();
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_hold_cpu got=%b exp=0", cpu_rst_n); end
        rst_n = 1'b1;
        tick();
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL rst_release_cpu got=%b exp=1", cpu_rst_n); end
    endtask

    task automatic test_two_words();
        int c0;
        clear_log();
        do_start(12'd2);
        c0 = cyc;
        checks++; if (busy !== 1'b1 || byte_ready !== 1'b1) begin failures++; $display("FAIL two_busy_ready got=%b%b exp=11", busy, byte_ready); end
        checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL two_cpu_hold got=%b exp=0", cpu_rst_n); end
        send_word(32'h3C08_1001);
        checks++; if (we !== 1'b1 || widx !== 11'd0) begin failures++; $display("FAIL two_w0_we_idx got=%b/%0d exp=1/0", we, widx); end
        checks++; if (waddr !== 32'h0040_0000 || wdata !== 32'h3C08_1001) begin failures++; $display("FAIL two_w0 got=%h/%h exp=00400000/3c081001", waddr, wdata); end
        send_word(32'h2408_0005);
        checks++; if (we !== 1'b1 || widx !== 11'd1) begin failures++; $display("FAIL two_w1_we_idx got=%b/%0d exp=1/1", we, widx); end
        checks++; if (waddr !== 32'h0040_0004 || wdata !== 32'h2408_0005) begin failures++; $display("FAIL two_w1 got=%h/%h exp=00400004/24080005", waddr, wdata); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL two_early_done got=%b exp=0", done); end
        tick();
        checks++; if (done !== 1'b1 || (cyc - c0) !== 10) begin failures++; $display("FAIL two_done got=%b@%0d exp=1@10", done, cyc - c0); end
        checks++; if (checksum !== 32'h1800_1004) begin failures++; $display("FAIL two_checksum got=%h exp=18001004", checksum); end
        checks++; if (busy !== 1'b0 || cpu_rst_n !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL two_post got=%b%b%b exp=010", busy, cpu_rst_n, we); end
        checks++; if (lw_idx.size() !== 2 || accepts !== 8) begin failures++; $display("FAIL two_counts got=%0d/%0d exp=2/8", lw_idx.size(), accepts); end
    endtask

    task automatic test_gappy();
        logic [7:0] bytes [4];
        int idx;
        int bad;
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC; bytes[3] = 8'hDD;
        idx = 0;
        bad = 0;
        clear_log();
        do_start(12'd1);
        for (int i = 0; i < 14; i++) begin
            byte_valid = (i % 2 == 0);
            byte_data = (idx < 4) ? bytes[idx] : 8'hEE;
            if (byte_valid && byte_ready) idx++;
            tick();
            if (busy === 1'b1 && cpu_rst_n !== 1'b0) bad++;
        end
        byte_valid = 1'b0;
        checks++; if (accepts !== 4) begin failures++; $display("FAIL gap_accepts got=%0d exp=4", accepts); end
        checks++; if (lw_data.size() !== 1) begin failures++; $display("FAIL gap_writes got=%0d exp=1", lw_data.size()); end
        if (lw_data.size() == 1) begin
            checks++; if (lw_data[0] !== 32'hAABB_CCDD || lw_idx[0] !== 11'd0) begin failures++; $display("FAIL gap_word got=%h@%0d exp=aabbccdd@0", lw_data[0], lw_idx[0]); end
        end
        checks++; if (checksum !== 32'hAABB_CCDD) begin failures++; $display("FAIL gap_checksum got=%h exp=aabbccdd", checksum); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL gap_cpu_hold got=%0d exp=0", bad); end
        checks++; if (done !== 1'b1 || cpu_rst_n !== 1'b1) begin failures++; $display("FAIL gap_done got=%b%b exp=11", done, cpu_rst_n); end
    endtask

    task automatic test_zero();
        clear_log();
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL zero_pre_cpu got=%b exp=1", cpu_rst_n); end
        do_start(12'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done got=%b%b exp=10", done, busy); end
        checks++; if (checksum !== 32'h0) begin failures++; $display("FAIL zero_checksum got=%h exp=0", checksum); end
        checks++; if (cpu_rst_n !== 1'b1 || byte_ready !== 1'b0) begin failures++; $display("FAIL zero_cpu_ready got=%b%b exp=10", cpu_rst_n, byte_ready); end
        tick();
        checks++; if (lw_data.size() !== 0) begin failures++; $display("FAIL zero_writes got=%0d exp=0", lw_data.size()); end
    endtask

    task automatic test_abort();
        clear_log();
        do_start(12'd3);
        send_word(32'h1122_3344);
        send_byte(8'h55);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin failures++; $display("FAIL abort_state got=%b%b%b exp=000", busy, done, byte_ready); end
        checks++; if (cpu_rst_n !== 1'b1) begin failures++; $display("FAIL abort_cpu got=%b exp=1", cpu_rst_n); end
        checks++; if (lw_data.size() !== 1) begin failures++; $display("FAIL abort_writes got=%0d exp=1", lw_data.size()); end
        if (lw_data.size() == 1) begin
            checks++; if (lw_data[0] !== 32'h1122_3344 || lw_idx[0] !== 11'd0) begin failures++; $display("FAIL abort_word got=%h@%0d exp=11223344@0", lw_data[0], lw_idx[0]); end
        end
        clear_log();
        do_start(12'd1);
        send_word(32'hDEAD_BEEF);
        abort = 1'b1;
        #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL abort_we_gate got=%b exp=0", we); end
        tick();
        abort = 1'b0;
        checks++; if (lw_data.size() !== 0 || done !== 1'b0) begin failures++; $display("FAIL abort_in_write got=%0d/%b exp=0/0", lw_data.size(), done); end
        clear_log();
        do_start(12'd1);
        send_word(32'h6677_8899);
        tick();
        checks++; if (lw_data.size() !== 1) begin failures++; $display("FAIL restart_writes got=%0d exp=1", lw_data.size()); end
        if (lw_data.size() == 1) begin
            checks++; if (lw_data[0] !== 32'h6677_8899 || lw_idx[0] !== 11'd0) begin failures++; $display("FAIL restart_word got=%h@%0d exp=66778899@0", lw_data[0], lw_idx[0]); end
        end
        checks++; if (checksum !== 32'h6677_8899 || done !== 1'b1) begin failures++; $display("FAIL restart_done got=%h/%b exp=66778899/1", checksum, done); end
    endtask

    task automatic test_clamp();
        logic [31:0] w;
        logic [31:0] csum;
        int errs;
        csum = '0;
        errs = 0;
        clear_log();
        do_start(12'hFFF);
        for (int i = 0; i < 2048; i++) begin
            w = {5'd0, 11'(i), 16'hC0DE ^ 16'(i)};
            csum = csum ^ w;
            if (i == 100) begin
                word_count = 12'd1;
                start = 1'b1;
                send_byte(w[31:24]);
                start = 1'b0;
                send_byte(w[23:16]);
                send_byte(w[15:8]);
                send_byte(w[7:0]);
            end else begin
                send_word(w);
            end
        end
        checks++; if (we !== 1'b1 || widx !== 11'd2047 || waddr !== 32'h0040_1FFC) begin failures++; $display("FAIL clamp_last got=%b/%0d/%h exp=1/2047/00401ffc", we, widx, waddr); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL clamp_done got=%b%b exp=10", done, busy); end
        checks++; if (lw_data.size() !== 2048) begin failures++; $display("FAIL clamp_writes got=%0d exp=2048", lw_data.size()); end
        for (int i = 0; i < 2048 && i < lw_data.size(); i++) begin
            w = {5'd0, 11'(i), 16'hC0DE ^ 16'(i)};
            if (lw_idx[i] !== 11'(i) || lw_data[i] !== w || lw_addr[i] !== 32'h0040_0000 + 32'(4 * i)) errs++;
        end
        checks++; if (errs !== 0) begin failures++; $display("FAIL clamp_sequence got=%0d exp=0 bad entries", errs); end
        checks++; if (checksum !== csum) begin failures++; $display("FAIL clamp_checksum got=%h exp=%h", checksum, csum); end
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
        checks++; if (accepts !== 8192) begin failures++; $display("FAIL clamp_accepts got=%0d exp=8192", accepts); end
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        do_start(12'd2);
        send_word(32'h0102_0304);
        send_word(32'hA0B0_C0D0);
        checks++; if (we !== 1'b1 || widx !== 11'd1 || checksum !== 32'h0102_0304) begin failures++; $display("FAIL rmw_pre got=%b/%0d/%h exp=1/1/01020304", we, widx, checksum); end
        rst_n = 1'b0;
        #1;
        checks++; if (we !== 1'b0 || byte_ready !== 1'b0) begin failures++; $display("FAIL rmw_we_ready got=%b%b exp=00", we, byte_ready); end
        checks++; if (widx !== 11'd0 || waddr !== 32'h0040_0000) begin failures++; $display("FAIL rmw_addr got=%0d/%h exp=0/00400000", widx, waddr); end
        checks++; if (wdata !== 32'h0 || checksum !== 32'h0) begin failures++; $display("FAIL rmw_data got=%h/%h exp=0/0", wdata, checksum); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rmw_status got=%b%b%b exp=000", busy, done, cpu_rst_n); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rmw_release got=%b%b exp=10", cpu_rst_n, busy); end
    endtask

    initial begin
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        word_count = '0; byte_data = '0; rst_n = 1'b1;
        test_reset();
        test_two_words();
        test_gappy();
        test_zero();
        test_abort();
        test_clamp();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
